// File: rtl/pimac_pipe_acc.sv
`default_nettype none
// ============================================================================
// Module   : pimac_pipe_acc
// Purpose  : Two-stage pipelined unsigned multiply-accumulate unit.
//            Stage 1 registers the exact product a*b together with c and
//            mode. Stage 2 adds either c (MAC, mode 0) or the current
//            accumulator (accumulate, mode 1) to the product. The sum is
//            then saturated or wrapped into the ACC_WIDTH result. Overflow
//            is sticky.
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            in_valid  - operation strobe; a/b/c/mode sampled when high
//            mode      - 0: result = a*b + c, 1: result = result + a*b
//            clear     - synchronous clear of result and overflow
//            a, b, c   - unsigned operands (c ignored in mode 1)
//            result    - registered result / accumulator
//            out_valid - one-cycle pulse when result was updated
//            overflow  - sticky overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module pimac_pipe_acc #(
  parameter int A_WIDTH   = 4,
  parameter int B_WIDTH   = 4,
  parameter int C_WIDTH   = 4,
  parameter int ACC_WIDTH = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic                 clear,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [C_WIDTH-1:0]   c,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 out_valid,
  output logic                 overflow
);

  localparam int P_W   = A_WIDTH + B_WIDTH;
  // One bit wider than the widest addend, so the sum can never lose a carry.
  localparam int SUM_W = ((P_W > ACC_WIDTH) ? P_W : ACC_WIDTH) + 1;

  // Stage 1 registers
  logic [P_W-1:0]     prod_q, prod_d;
  logic [C_WIDTH-1:0] c_q, c_d;
  logic               mode_q, mode_d;
  logic               s1_valid_q, s1_valid_d;

  // Stage 2 / output registers
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 overflow_q, overflow_d;
  logic                 out_valid_q, out_valid_d;

  // Stage 2 datapath
  logic [SUM_W-1:0]     addend;
  logic [SUM_W-1:0]     sum;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] sum_fit;

  // --------------------------------------------------------------------------
  // Stage 1: operands are only captured while in_valid is high. With
  // in_valid low the data registers hold. Unknown operand values on idle
  // cycles therefore never enter the datapath.
  // --------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = in_valid;
    prod_d     = prod_q;
    c_d        = c_q;
    mode_d     = mode_q;
    if (in_valid) begin
      prod_d = P_W'(a) * P_W'(b);
      c_d    = c;
      mode_d = mode;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2 arithmetic. Accumulate mode reads result_q directly. Each op
  // therefore sees the previous op's result even when ops are back-to-back.
  // --------------------------------------------------------------------------
  always_comb begin
    addend  = mode_q ? SUM_W'(result_q) : SUM_W'(c_q);
    sum     = addend + SUM_W'(prod_q);
    sum_ovf = |sum[SUM_W-1:ACC_WIDTH];
  end

  generate
    if (SATURATE) begin : g_saturate
      assign sum_fit = sum_ovf ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    end else begin : g_wrap
      assign sum_fit = sum[ACC_WIDTH-1:0];
    end
  endgenerate

  // clear wins over a coincident stage-2 op. That op is dropped silently.
  always_comb begin
    result_d    = result_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    if (clear) begin
      result_d   = '0;
      overflow_d = 1'b0;
    end else if (s1_valid_q) begin
      result_d    = sum_fit;
      overflow_d  = overflow_q | sum_ovf;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q      <= '0;
      c_q         <= '0;
      mode_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      prod_q      <= prod_d;
      c_q         <= c_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pimac_pipe_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pimac_pipe_acc
// Purpose  : Self-checking bench for pimac_pipe_acc. One saturating instance
//            and one wrapping instance receive identical stimulus. Expected
//            responses go into per-instance queues. Monitors pop the queues on
//            every out_valid and check the value, the flag and the cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pimac_pipe_acc;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       mode;
  logic       clear;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;

  logic [7:0] res_s, res_w;
  logic       ov_s, ov_w;
  logic       ovf_s, ovf_w;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q_sat[$];
  exp_t q_wrap[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  pimac_pipe_acc #(
    .A_WIDTH(4), .B_WIDTH(4), .C_WIDTH(4), .ACC_WIDTH(8), .SATURATE(1'b1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .clear(clear), .a(a), .b(b), .c(c),
    .result(res_s), .out_valid(ov_s), .overflow(ovf_s)
  );

  pimac_pipe_acc #(
    .A_WIDTH(4), .B_WIDTH(4), .C_WIDTH(4), .ACC_WIDTH(8), .SATURATE(1'b0)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .clear(clear), .a(a), .b(b), .c(c),
    .result(res_w), .out_valid(ov_w), .overflow(ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one op for one cycle. The result is due after two more edges.
  task automatic issue(input logic [3:0] ia, input logic [3:0] ib,
                       input logic [3:0] ic, input logic imode,
                       input bit push,
                       input logic [7:0] es, input logic eos,
                       input logic [7:0] ew, input logic eow);
    exp_t e;
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    c        = ic;
    mode     = imode;
    if (push) begin
      e.cyc = cyc + 2;
      e.res = es;  e.ovf = eos; q_sat.push_back(e);
      e.res = ew;  e.ovf = eow; q_wrap.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    c        = 'x;
    mode     = 1'bx;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_res_sat"},  int'(res_s), 0);
    check({tag, "_ov_sat"},   int'(ov_s),  0);
    check({tag, "_ovf_sat"},  int'(ovf_s), 0);
    check({tag, "_res_wrap"}, int'(res_w), 0);
    check({tag, "_ov_wrap"},  int'(ov_w),  0);
    check({tag, "_ovf_wrap"}, int'(ovf_w), 0);
  endtask

  // Monitors: every out_valid must match the oldest expected entry.
  always @(negedge clk) begin
    if (ov_s) begin
      if (q_sat.size() == 0) begin
        check("sat_unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_sat.pop_front();
        check("sat_result",   int'(res_s), int'(e.res));
        check("sat_overflow", int'(ovf_s), int'(e.ovf));
        check("sat_latency",  cyc,         e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ov_w) begin
      if (q_wrap.size() == 0) begin
        check("wrap_unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q_wrap.pop_front();
        check("wrap_result",   int'(res_w), int'(e.res));
        check("wrap_overflow", int'(ovf_w), int'(e.ovf));
        check("wrap_latency",  cyc,         e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    a = '0; b = '0; c = '0; mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic MAC: 3*5+2 = 17
    issue(4'd3, 4'd5, 4'd2, 1'b0, 1'b1, 8'd17, 1'b0, 8'd17, 1'b0);
    idle();
    repeat (3) begin @(posedge clk); #1; end

    // Max MAC twice back-to-back: 225+15 = 240, no overflow
    issue(4'd15, 4'd15, 4'd15, 1'b0, 1'b1, 8'd240, 1'b0, 8'd240, 1'b0);
    issue(4'd15, 4'd15, 4'd15, 1'b0, 1'b1, 8'd240, 1'b0, 8'd240, 1'b0);
    idle();
    repeat (3) begin @(posedge clk); #1; end

    // Clear, then chained accumulates: 225, 450, 451
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    issue(4'd15, 4'd15, 4'd0, 1'b1, 1'b1, 8'd225, 1'b0, 8'd225, 1'b0);
    issue(4'd15, 4'd15, 4'd0, 1'b1, 1'b1, 8'd255, 1'b1, 8'd194, 1'b1);
    issue(4'd1,  4'd1,  4'd0, 1'b1, 1'b1, 8'd255, 1'b1, 8'd195, 1'b1);
    idle();
    repeat (3) begin @(posedge clk); #1; end

    // clear meets a stage-2 op (dropped) while a new op enters stage 1
    issue(4'd1, 4'd1, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    clear = 1'b1;
    issue(4'd2, 4'd3, 4'd0, 1'b1, 1'b1, 8'd6, 1'b0, 8'd6, 1'b0);
    clear = 1'b0;
    idle();
    @(negedge clk);
    check_quiet("clear_cycle");
    repeat (3) begin @(posedge clk); #1; end

    // Build up overflow again: 6+225 = 231, then 456
    issue(4'd15, 4'd15, 4'd0, 1'b1, 1'b1, 8'd231, 1'b0, 8'd231, 1'b0);
    issue(4'd15, 4'd15, 4'd0, 1'b1, 1'b1, 8'd255, 1'b1, 8'd200, 1'b1);
    idle();
    repeat (3) begin @(posedge clk); #1; end

    // Reset pulse with ops in flight: none of them may emerge
    issue(4'd1, 4'd1, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    a = 4'd2; b = 4'd2; c = 4'd0; mode = 1'b1; in_valid = 1'b1;
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle();
    repeat (3) begin
      @(negedge clk);
      check_quiet("post_reset");
    end

    repeat (3) begin @(posedge clk); #1; end
    check("sat_queue_left",  q_sat.size(),  0);
    check("wrap_queue_left", q_wrap.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pimac_pipe_acc.md
Name: pimac_pipe_acc

Overview:
- Parametrised, two-stage pipelined multiply-accumulate unit; the successor to the fixed 4x4+4 -> 8 PiMAC.
- Two modes per operation: fused MAC (a*b + c) or running accumulate (acc + a*b).
- Optional saturation, sticky overflow flag, valid strobes in and out.
- Instantiated inside the TinyTapeout top wrapper; the wrapper maps ui_in/uio_in to the operands and uo_out to result.

Parameters:
- A_WIDTH, 4, width of unsigned operand a
- B_WIDTH, 4, width of unsigned operand b
- C_WIDTH, 4, width of unsigned addend c (must be <= ACC_WIDTH)
- ACC_WIDTH, 8, width of result/accumulator register
- SATURATE, 1, 1 = clamp to 2^ACC_WIDTH-1 on overflow; 0 = wrap modulo 2^ACC_WIDTH

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation strobe; a, b, c, mode sampled when high
- mode  in  1  0 = MAC (a*b+c), 1 = accumulate (result+a*b)
- clear  in  1  synchronous clear of accumulator and overflow flag
- a  in  A_WIDTH  multiplicand
- b  in  B_WIDTH  multiplier
- c  in  C_WIDTH  addend (ignored in mode 1)
- result  out  ACC_WIDTH  registered result/accumulator
- out_valid  out  1  one-cycle pulse: result updated this cycle
- overflow  out  1  sticky: set when any op exceeded 2^ACC_WIDTH-1

Behaviour:
- Reset (rst_n low, async): result=0, out_valid=0, overflow=0, both stage valid bits=0; pipeline contents discarded. After release, no pulse for ops issued before/during reset.
- All ops unsigned. Product P = a*b, A_WIDTH+B_WIDTH bits, exact.
- Stage 1 (edge after in_valid high): register P, c, mode, s1_valid. If in_valid low: s1_valid=0, other s1 regs don't-care.
- Stage 2 (next edge, s1_valid=1):
  - sum computed in max(A_WIDTH+B_WIDTH, ACC_WIDTH)+1 bits, no loss
  - mode 0: sum = P + zero-extended c
  - mode 1: sum = result (current register value) + P
  - if sum > 2^ACC_WIDTH-1: overflow <= 1; result <= all-ones if SATURATE=1, else sum mod 2^ACC_WIDTH
  - otherwise result <= sum
  - out_valid <= 1 for exactly one cycle
- Latency: in_valid at edge N -> result/out_valid visible after edge N+2. Throughput one op per cycle.
- Back-to-back accumulates chain correctly: each stage-2 op sees the previous op's result, no bubbles needed.
- No op in stage 2: result and overflow hold; out_valid=0.
- clear (sampled on edge): result <= 0, overflow <= 0.
  - Priority over a coincident stage-2 op: that op is dropped, out_valid=0.
  - An op captured into stage 1 on the same edge is unaffected and completes next cycle against result=0.
- mode 0 overwrites the accumulator; overflow never clears except by clear or reset.
- Inputs only sampled when in_valid=1; X on a/b/c/mode with in_valid=0 must not propagate.

Test Plan (defaults unless stated):
- Reset, then in_valid pulse a=3,b=5,c=2,mode=0 at edge N -> result=17, out_valid=1 after edge N+2 only; overflow=0.
- Max MAC: a=15,b=15,c=15,mode=0 -> result=240, overflow=0; next a=15,b=15,c=15 again -> still 240, no change to overflow.
- Accumulate with SATURATE=1: clear, then consecutive-cycle mode=1 ops (15,15),(15,15),(1,1) -> results 225, 255 (overflow=1), 255; overflow remains 1.
- Accumulate with SATURATE=0: same stimulus -> 225, 194, 195; overflow=1.
- clear coinciding with stage-2 op and a new op entering stage 1 (mode=1, a=2,b=3) -> result=0 with no out_valid that cycle, then 6 with out_valid next cycle; overflow=0.
- Assert rst_n low for one cycle while two ops are in flight -> result=0, out_valid stays 0 through the following 3 cycles, overflow=0.
